pipelined_barrel_shifter_left_logical: RTL

- Pipelined 64-bit logical left shifter for the ALU shift path, with valid/ready handshakes on both sides.
- It has one register stage per shift-amount bit (6 stages), so a new operand can be accepted every cycle.
- The upper 58 bits of the shift operand are ignored: shift amount = _shift[5:0].

---
 rtl/pipelined_barrel_shifter_left_logical.sv | 107 ++++++++++
 1 files changed

// File: rtl/pipelined_barrel_shifter_left_logical.sv
// rtl/pipelined_barrel_shifter_left_logical.sv - six-stage pipelined 64-bit logical left shifter
//
// Purpose: shifts data left by _shift[SHAMT_BITS-1:0]. Stage k applies the
// 2^k term of the shift amount, so one operand can be accepted every cycle.
// Under backpressure, empty stages (bubbles) close up, so up to SHAMT_BITS
// operations can be held.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair presented
//   in_ready   shifter can accept this cycle
//   data       value to shift
//   _shift     shift amount; only bits [SHAMT_BITS-1:0] are used
//   out_valid  result present
//   out_ready  consumer accepts result
//   out        shifted result
module pipelined_barrel_shifter_left_logical #(
  parameter int WIDTH      = 64,
  parameter int SHAMT_BITS = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] _shift,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out
);

  // Mask of the shift-amount bits that a stage still has to pass downstream.
  // Bits at or below k have already been applied and are dropped.
  function automatic logic [SHAMT_BITS-1:0] upper_mask(input int k);
    upper_mask = '0;
    for (int b = 0; b < SHAMT_BITS; b++) begin
      if (b > k) upper_mask[b] = 1'b1;
    end
  endfunction

  logic [SHAMT_BITS-1:0] v_q;
  logic [WIDTH-1:0]      d_q   [SHAMT_BITS];
  // The last stage needs no remaining shift bits, so there is one fewer register.
  logic [SHAMT_BITS-1:0] sh_q  [SHAMT_BITS-1];

  logic [SHAMT_BITS-1:0] v_in;
  logic [WIDTH-1:0]      d_in  [SHAMT_BITS];
  logic [SHAMT_BITS-1:0] s_in  [SHAMT_BITS];
  logic [WIDTH-1:0]      d_nxt [SHAMT_BITS];
  logic [SHAMT_BITS-1:0] adv;

  // The upper operand bits do not take part in the shift.
  logic unused_shift_bits;
  assign unused_shift_bits = ^_shift[WIDTH-1:SHAMT_BITS];

  // Stage k may advance unless it and every stage after it are full while the
  // consumer stalls. This is the same as adv[k] = !v[k] | adv[k+1], written as
  // a running AND over the valid bits so that no bit of adv feeds another.
  always_comb begin : adv_chain
    logic all_full;
    all_full = 1'b1;
    adv      = '0;
    for (int k = SHAMT_BITS - 1; k >= 0; k--) begin
      all_full = all_full & v_q[k];
      adv[k]   = ~all_full | out_ready;
    end
  end

  assign v_in[0] = in_valid;
  assign d_in[0] = data;
  assign s_in[0] = _shift[SHAMT_BITS-1:0];

  for (genvar k = 1; k < SHAMT_BITS; k++) begin : g_link
    assign v_in[k] = v_q[k-1];
    assign d_in[k] = d_q[k-1];
    assign s_in[k] = sh_q[k-1];
  end

  for (genvar k = 0; k < SHAMT_BITS; k++) begin : g_shift
    assign d_nxt[k] = s_in[k][k] ? (d_in[k] << (2 ** k)) : d_in[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int k = 0; k < SHAMT_BITS; k++) d_q[k] <= '0;
      for (int k = 0; k < SHAMT_BITS - 1; k++) sh_q[k] <= '0;
    end else begin
      for (int k = 0; k < SHAMT_BITS; k++) begin
        if (adv[k]) begin
          v_q[k] <= v_in[k];
          // Bubbles carry zero so that idle-time operands never reach out.
          d_q[k] <= v_in[k] ? d_nxt[k] : '0;
        end
      end
      for (int k = 0; k < SHAMT_BITS - 1; k++) begin
        if (adv[k]) sh_q[k] <= v_in[k] ? (s_in[k] & upper_mask(k)) : '0;
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = v_q[SHAMT_BITS-1];
  assign out       = d_q[SHAMT_BITS-1];

endmodule
